mux2_sync: RTL and testbench

//   Two-input, WIDTH-bit selector with a registered output stage.
//   Sel=0 forwards A; Sel=1 forwards B.

---
 rtl/mux2_sync.sv | 29 ++
 tb/tb_mux2_sync.sv | 91 +++++++++
 2 files changed

// File: rtl/mux2_sync.sv
// mux2_sync: WIDTH-bit 2:1 selector (Sel ? B : A); REG_OUT=1 adds an enabled output register with sync reset and a valid flag, REG_OUT=0 is purely combinational with out_valid tied high
module mux2_sync #(
  parameter int WIDTH = 4,
  parameter bit REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  output logic [WIDTH-1:0] Out,
  output logic             out_valid
);
  logic [WIDTH-1:0] mux_d, q;
  logic             v;
  assign mux_d = Sel ? B : A;
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      v <= 1'b0;
    end else if (en) begin
      q <= mux_d;
      v <= 1'b1;
    end
  end
  assign Out       = REG_OUT ? q : mux_d;
  assign out_valid = REG_OUT ? v : 1'b1;
endmodule

// File: tb/tb_mux2_sync.sv
// tb_mux2_sync: table, random and combinational-mode checks of mux2_sync
module tb_mux2_sync;
  logic clk = 1'b0;
  logic rst, en, sel, sel8;
  logic [3:0] a, b, out4;
  logic [7:0] a8, b8, out8;
  logic v4, v8;
  int n = 0, bad = 0;
  always #5 clk = ~clk;
  mux2_sync #(.WIDTH(4), .REG_OUT(1)) d1 (
    .clk(clk), .rst(rst), .en(en), .A(a), .B(b), .Sel(sel), .Out(out4), .out_valid(v4)
  );
  mux2_sync #(.WIDTH(8), .REG_OUT(0)) d0 (
    .clk(clk), .rst(rst), .en(en), .A(a8), .B(b8), .Sel(sel8), .Out(out8), .out_valid(v8)
  );
  typedef struct packed {
    logic       rst, en, sel;
    logic [3:0] a, b, q;
    logic       v;
  } vec_t;
  vec_t tbl[16];
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    logic [3:0] q_m;
    logic       v_m;
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'b1010, 4'b0101, 4'b0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 4'b1010, 4'b0101, 4'b0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'b1010, 4'b0101, 4'b1010, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 4'b1010, 4'b0101, 4'b0101, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 4'b1111, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 4'b1111, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'b0011, 4'b1100, 4'b1111, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1001, 4'b1111, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'b0110, 4'b0110, 4'b1111, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 4'b1111, 4'b0101, 4'b0000, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 4'b1111, 4'b0101, 4'b0101, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 4'b1100, 4'b0011, 4'b0000, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 4'b1100, 4'b0011, 4'b0000, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 4'b1100, 4'b0011, 4'b0011, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 4'b1100, 4'b0011, 4'b1100, 1'b1};
    rst = 1'b1; en = 1'b1; sel = 1'b0; a = '0; b = '0;
    sel8 = 1'b0; a8 = '0; b8 = '0;
    for (int i = 0; i < 16; i++) begin
      {rst, en, sel, a, b} = {tbl[i].rst, tbl[i].en, tbl[i].sel, tbl[i].a, tbl[i].b};
      @(posedge clk); #1;
      check($sformatf("tbl%0d_out", i), {4'h0, out4}, {4'h0, tbl[i].q});
      check($sformatf("tbl%0d_valid", i), {7'h0, v4}, {7'h0, tbl[i].v});
    end
    q_m = 4'b1100; v_m = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(15) == 0);
      en  = ($urandom_range(3) != 0);
      sel = 1'($urandom);
      a   = 4'($urandom);
      b   = 4'($urandom);
      if (rst) begin
        q_m = 4'h0; v_m = 1'b0;
      end else if (en) begin
        q_m = sel ? b : a; v_m = 1'b1;
      end
      @(posedge clk); #1;
      check("rand_out", {4'h0, out4}, {4'h0, q_m});
      check("rand_valid", {7'h0, v4}, {7'h0, v_m});
    end
    a8 = 8'hA5; b8 = 8'h3C; sel8 = 1'b0; #1;
    check("comb_sel0", out8, 8'hA5);
    check("comb_valid", {7'h0, v8}, 8'h01);
    sel8 = 1'b1; #1;
    check("comb_sel1", out8, 8'h3C);
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    check("comb_rst_ignored", out8, 8'h3C);
    check("comb_rst_valid", {7'h0, v8}, 8'h01);
    for (int i = 0; i < 100; i++) begin
      sel8 = 1'($urandom);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      #1;
      check("comb_rand", out8, sel8 ? b8 : a8);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
